// File: rtl/seg7_pkg.sv
// Shared constants for the scanned seven-segment reader.
// Hex letter patterns are only decoded when SEG7_HEX_EN is defined.
package seg7_pkg;

  localparam int NUM_DIGITS = 3;

  localparam int DIG_ONES  = 0;
  localparam int DIG_TENS  = 1;
  localparam int DIG_HUNDS = 2;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Active-low segment pattern to BCD digit, blank and invalid flags.
// Define SEG7_HEX_EN to also accept the A..F letter patterns.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       blank,
  output logic       invalid
);

  always_comb begin
    digit   = 4'd0;
    blank   = 1'b0;
    invalid = 1'b0;
    unique case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
`ifdef SEG7_HEX_EN
      SEG_HEX_A: digit = 4'd10;
      SEG_HEX_B: digit = 4'd11;
      SEG_HEX_C: digit = 4'd12;
      SEG_HEX_D: digit = 4'd13;
      SEG_HEX_E: digit = 4'd14;
      SEG_HEX_F: digit = 4'd15;
`endif
      SEG_BLANK: blank = 1'b1;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reconstructs three BCD digits from a scanned active-low 7-seg bus.
// Hex letters are accepted only when SEG7_HEX_EN is defined.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter  int STABLE_CYCLES = 4,
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [6:0] iSEG,
  input  logic [2:0] iDIG_SEL,
  output logic [3:0] oD1,
  output logic [3:0] oD2,
  output logic [3:0] oD3,
  output logic [2:0] oBLANK,
  output logic       oERR,
  output logic       oVALID,
  input  logic       iREADY,
  output logic       oDROP
);

  logic [6:0] seg_q;
  logic [2:0] sel_q;
  logic [CNT_W-1:0] cnt;

  logic [NUM_DIGITS-1:0][3:0] slot_dig;
  logic [NUM_DIGITS-1:0] slot_blank;
  logic [NUM_DIGITS-1:0] slot_inv;
  logic [NUM_DIGITS-1:0] seen;
  logic frame_err;

  logic [3:0] dec_dig;
  logic dec_blank;
  logic dec_inv;

  logic cap;
  logic slot_wr;
  logic sel_err;
  logic [1:0] slot;
  logic complete;
  logic free;

  seg7_pattern_decode u_dec (
    .pattern (seg_q),
    .digit   (dec_dig),
    .blank   (dec_blank),
    .invalid (dec_inv)
  );

  assign cap      = (cnt == CNT_W'(STABLE_CYCLES - 1));
  assign complete = &seen;
  assign free     = !oVALID || iREADY;

  always_comb begin
    slot_wr = 1'b0;
    sel_err = 1'b0;
    slot    = 2'(DIG_ONES);
    unique case (sel_q)
      3'b110: begin
        slot_wr = cap;
        slot    = 2'(DIG_ONES);
      end
      3'b101: begin
        slot_wr = cap;
        slot    = 2'(DIG_TENS);
      end
      3'b011: begin
        slot_wr = cap;
        slot    = 2'(DIG_HUNDS);
      end
      3'b111: ;
      default: sel_err = cap;
    endcase
  end

  // cnt counts how long the new sample has matched the previous one
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      seg_q <= '0;
      sel_q <= '0;
      cnt   <= '0;
    end else begin
      seg_q <= iSEG;
      sel_q <= iDIG_SEL;
      if ({iSEG, iDIG_SEL} == {seg_q, sel_q}) begin
        if (cnt != CNT_W'(STABLE_CYCLES))
          cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  // completion takes priority: a capture in that cycle is dropped
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      slot_dig   <= '0;
      slot_blank <= '0;
      slot_inv   <= '0;
      seen       <= '0;
      frame_err  <= 1'b0;
    end else if (complete) begin
      seen      <= '0;
      frame_err <= 1'b0;
    end else begin
      if (slot_wr) begin
        slot_dig[slot]   <= dec_dig;
        slot_blank[slot] <= dec_blank;
        slot_inv[slot]   <= dec_inv;
        seen[slot]       <= 1'b1;
      end
      if (sel_err)
        frame_err <= 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oD1    <= '0;
      oD2    <= '0;
      oD3    <= '0;
      oBLANK <= '0;
      oERR   <= 1'b0;
      oVALID <= 1'b0;
      oDROP  <= 1'b0;
    end else begin
      oDROP <= complete && !free;
      if (complete && free) begin
        oD1    <= slot_dig[DIG_ONES];
        oD2    <= slot_dig[DIG_TENS];
        oD3    <= slot_dig[DIG_HUNDS];
        oBLANK <= slot_blank;
        oERR   <= (|slot_inv) | frame_err;
        oVALID <= 1'b1;
      end else if (iREADY) begin
        oVALID <= 1'b0;
      end
    end
  end

endmodule
